// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum shift accumulator.
// Holds default widths, the FSM state enum and the term alignment function.
package psum_pkg;

    localparam int IN_W  = 8;
    localparam int ACC_W = 24;
    localparam int SH_W  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Sign-extend a PE partial sum to accumulator width, then weight it
    // by its brick-group bit position.
    function automatic logic signed [ACC_W-1:0] align_term(
        input logic signed [IN_W-1:0] v,
        input logic        [SH_W-1:0] sh
    );
        logic signed [ACC_W-1:0] ext;
        ext = ACC_W'(v);
        return ext <<< sh;
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Signed W-bit adder; saturates and flags overflow when PSUM_ACC_SAT_EN
// is defined, otherwise wraps and drives ovf low.
// Ports: a, b (operands), sum (result), ovf (saturation occurred).
module psum_sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

`ifdef PSUM_ACC_SAT_EN
    logic [W:0] wide;

    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        // Extra sign bit disagreeing with the top result bit means the
        // true sum left the representable range.
        ovf  = wide[W] ^ wide[W-1];
        sum  = wide[W-1:0];
        if (ovf) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}}
                          : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum = a + b;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/psum_shift_accumulator.sv
// Shift-aligns PE partial sums and accumulates them per sequence; holds
// the finished result until downstream accepts it (PSUM_ACC_SAT_EN: sat).
// Ports: clk, reset (async low), in_valid/in_ready/pe_sum/in_shift/in_last,
// out_valid/out_ready/out_acc/out_beats/out_ovf.
module psum_shift_accumulator #(
    parameter int IN_W      = psum_pkg::IN_W,
    parameter int ACC_W     = psum_pkg::ACC_W,
    parameter int SH_W      = psum_pkg::SH_W,
    parameter int CNT_W     = 8,
    parameter int MAX_BEATS = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  pe_sum,
    input  logic [SH_W-1:0]  in_shift,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    import psum_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf;
    logic             add_ovf;
    logic             take;
    logic             seq_end;
    logic             drain;

    assign term = align_term(pe_sum, in_shift);

    psum_sat_add #(
        .W(ACC_W)
    ) u_add (
        .a   (acc),
        .b   (term),
        .sum (sum),
        .ovf (add_ovf)
    );

    assign take    = in_valid & in_ready;
    assign drain   = out_valid & out_ready;
    assign cnt_nxt = cnt + CNT_W'(1);
    assign seq_end = in_last | (cnt_nxt == CNT_W'(MAX_BEATS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && seq_end) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // The running registers double as the held result: they freeze in
    // HOLD because no beat is accepted there, and clear on the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (take) begin
            acc <= sum;
            cnt <= cnt_nxt;
            ovf <= ovf | add_ovf;
        end else if (drain) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    assign out_acc   = acc;
    assign out_beats = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_psum_shift_accumulator.sv
// Randomized and directed bench for psum_shift_accumulator against a
// sequence-level arithmetic model.
module tb_psum_shift_accumulator;

    localparam int MAXB = 4;
    localparam longint HALF = 64'sd8388608;
    localparam longint FULL = 64'sd16777216;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  pe_sum;
    logic [3:0]  in_shift;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_acc;
    logic [7:0]  out_beats;
    logic        out_ovf;

    int n_cmp;
    int n_bad;

    bit     m_hold;
    longint m_acc;
    int     m_n;
    bit     m_ovf;

    psum_shift_accumulator #(
        .CNT_W    (8),
        .MAX_BEATS(MAXB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pe_sum   (pe_sum),
        .in_shift (in_shift),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_beats(out_beats),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap24(input longint x);
        longint t;
        t = x & 64'hFFFFFF;
        if (t >= HALF) t = t - FULL;
        return t;
    endfunction

    task automatic model_clear();
        m_hold = 0;
        m_acc  = 0;
        m_n    = 0;
        m_ovf  = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".in_ready"}, longint'(in_ready), longint'(!m_hold));
        chk({tag, ".out_valid"}, longint'(out_valid), longint'(m_hold));
        if (m_hold) begin
            chk({tag, ".out_acc"}, longint'($signed(out_acc)), m_acc);
            chk({tag, ".out_beats"}, longint'(out_beats), longint'(m_n));
            chk({tag, ".out_ovf"}, longint'(out_ovf), longint'(m_ovf));
        end
    endtask

    // One clock: drive inputs, predict the effect of the coming edge,
    // then compare just after that edge.
    task automatic step(input bit v, input int pe, input int sh,
                        input bit lst, input bit ordy, input string tag);
        longint s;
        in_valid  = v;
        pe_sum    = pe[7:0];
        in_shift  = sh[3:0];
        in_last   = lst;
        out_ready = ordy;
        if (m_hold) begin
            if (ordy) model_clear();
        end else if (v) begin
            s = m_acc + longint'(pe) * (64'sd1 << sh);
`ifdef PSUM_ACC_SAT_EN
            if (s > HALF - 1) begin
                s = HALF - 1;
                m_ovf = 1;
            end else if (s < -HALF) begin
                s = -HALF;
                m_ovf = 1;
            end
`else
            s = wrap24(s);
`endif
            m_acc = s;
            m_n++;
            if (lst || m_n == MAXB) m_hold = 1;
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk({tag, ".rst_valid"}, longint'(out_valid), 0);
        chk({tag, ".rst_acc"}, longint'(out_acc), 0);
        chk({tag, ".rst_beats"}, longint'(out_beats), 0);
        chk({tag, ".rst_ovf"}, longint'(out_ovf), 0);
        chk({tag, ".rst_ready"}, longint'(in_ready), 1);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        pe_sum    = '0;
        in_shift  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #3;
        chk("reset.out_valid", longint'(out_valid), 0);
        chk("reset.out_acc", longint'(out_acc), 0);
        chk("reset.out_beats", longint'(out_beats), 0);
        chk("reset.out_ovf", longint'(out_ovf), 0);
        #9;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("idle");

        // Basic accumulate: 5 + (-3<<2) + (7<<4) = 105
        step(1, 5, 0, 0, 1, "basic0");
        step(1, -3, 2, 0, 1, "basic1");
        step(1, 7, 4, 1, 1, "basic2");
        chk("basic.acc105", longint'($signed(out_acc)), 105);
        step(0, 0, 0, 0, 1, "basic_drain");

        // Backpressure with new data offered while holding
        step(1, 5, 0, 0, 0, "bp0");
        step(1, -3, 2, 0, 0, "bp1");
        step(1, 7, 4, 1, 0, "bp2");
        for (int i = 0; i < 10; i++) step(1, 9, 1, 0, 0, "bp_hold");
        chk("bp.acc105", longint'($signed(out_acc)), 105);
        step(1, 9, 1, 0, 1, "bp_release");
        step(1, 2, 1, 1, 0, "bp_next");
        chk("bp.fresh", longint'($signed(out_acc)), 4);
        step(0, 0, 0, 0, 1, "bp_drain");

        // Forced end after MAXB beats without in_last
        for (int i = 0; i < MAXB; i++) step(1, 1, 0, 0, 0, "force");
        chk("force.beats", longint'(out_beats), MAXB);
        chk("force.acc", longint'($signed(out_acc)), MAXB);
        step(0, 0, 0, 0, 1, "force_drain");

        // Overflow: three beats of 127<<15
        step(1, 127, 15, 0, 0, "ovf0");
        step(1, 127, 15, 0, 0, "ovf1");
        step(1, 127, 15, 1, 0, "ovf2");
`ifdef PSUM_ACC_SAT_EN
        chk("ovf.acc_sat", longint'($signed(out_acc)), 8388607);
        chk("ovf.flag", longint'(out_ovf), 1);
`else
        chk("ovf.acc_wrap", longint'($signed(out_acc)), -4292608);
        chk("ovf.flag", longint'(out_ovf), 0);
`endif
        step(0, 0, 0, 0, 1, "ovf_drain");

        // Async reset mid-sequence and in HOLD
        step(1, 50, 3, 0, 0, "ar0");
        step(1, -20, 5, 0, 0, "ar1");
        async_reset("ar_mid");
        step(1, 3, 2, 1, 0, "ar2");
        async_reset("ar_hold");
        step(1, -128, 0, 1, 0, "ar_neg");
        chk("ar.acc_neg", longint'($signed(out_acc)), -128);
        step(0, 0, 0, 0, 1, "ar_drain");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0),
                 int'($urandom_range(255)) - 128,
                 int'($urandom_range(15)),
                 ($urandom_range(5) == 0),
                 ($urandom_range(1) == 1),
                 "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_shift_accumulator.md
Name: psum_shift_accumulator

Overview:
- Sits directly downstream of the PE fusion unit and consumes its 8-bit signed PE_sum each beat.
- Each partial sum is aligned by a per-beat shift that gives the bit-position weight of the 2-bit brick group. Aligned values are accumulated over a multi-beat sequence to build full-precision dot products.
- A valid/ready handshake on both sides lets the block stall the PE array while a finished result waits for the output buffer/writeback stage.

Parameters:
- IN_W, 8, width of signed PE_sum input
- ACC_W, 24, width of signed accumulator and result
- SH_W, 4, width of shift-amount field (max shift 15)
- CNT_W, 8, width of beat counter
- MAX_BEATS, 255, beat count that forces sequence end if in_last never arrives

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  PE_sum beat valid
- in_ready  out  1  block accepts beat
- pe_sum  in  IN_W  signed partial sum from PE
- in_shift  in  SH_W  left-shift (bit weight) for this beat
- in_last  in  1  final beat of current sequence
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  signed accumulated result
- out_beats  out  CNT_W  number of beats in result
- out_ovf  out  1  overflow flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=ACCUM, acc=0, beat count=0, out_valid=0, out_acc=0, out_beats=0, out_ovf=0, in_ready=1 after release.
- FSM has two states, ACCUM and HOLD.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- A beat is accepted when in_valid & in_ready.
  - term = sign-extend(pe_sum) to ACC_W, then arithmetic shift left by in_shift.
  - acc <= acc + term; cnt <= cnt+1.
- End of sequence: an accepted beat with in_last=1, or an accepted beat making cnt+1 == MAX_BEATS.
  - Next cycle: state=HOLD, out_valid=1, out_acc = acc+term, out_beats = cnt+1.
  - Latency from last accepted beat to out_valid is 1 cycle.
- In HOLD:
  - out_acc, out_beats and out_ovf stay stable until out_valid & out_ready.
  - On that handshake: acc=0, cnt=0, ovf=0, state=ACCUM, out_valid=0 the next cycle.
  - No same-cycle bypass: a new beat can be accepted at the earliest 1 cycle after the output handshake.
- in_valid=0 in ACCUM: no change; there is no timeout.
- in_shift=0 means unshifted.
- Arithmetic without SAT_EN is two's-complement wrap modulo 2^ACC_W.
- Reset asserted mid-sequence or in HOLD discards the partial/held result immediately.
- out_ready asserted while in ACCUM is ignored.

Optional Feature:
- Macro PSUM_ACC_SAT_EN.
- Defined:
  - Each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - out_ovf is a sticky flag set if any beat in the sequence saturated; it is cleared on output handshake or reset.
- Undefined:
  - Accumulation wraps.
  - out_ovf is tied to 0.
  - No saturation logic is synthesized.

Decomposition:
- Shared package psum_pkg holds:
  - localparams IN_W/ACC_W/SH_W defaults
  - state enum (ACCUM, HOLD)
  - function align_term(pe_sum, shift) returning the sign-extended, shifted ACC_W value.
- One natural sub-module: psum_sat_add (ACC_W adder with optional saturation and overflow output), instantiated once. Its saturation path is compiled only under PSUM_ACC_SAT_EN.

Test Plan:
- Basic accumulate:
  - Stimulus: beats (5,sh0), (-3,sh2), (7,sh4,last), out_ready=1.
  - Response: out_acc=105, out_beats=3, out_valid one cycle after last beat, in_ready=0 for exactly that cycle.
- Backpressure:
  - Stimulus: same sequence, out_ready=0 for 10 cycles, in_valid held high with new data.
  - Response: out_acc stays 105, in_ready=0, no beat absorbed; after out_ready=1, next sequence starts from acc=0.
- Forced end:
  - Stimulus: MAX_BEATS=4, four beats of (1,sh0) with in_last=0.
  - Response: out_beats=4, out_acc=4.
- Overflow, without macro:
  - Stimulus: three beats of (127,sh15).
  - Response: out_acc = -4292608 (wrapped), out_ovf=0.
- Overflow, with PSUM_ACC_SAT_EN:
  - Stimulus: three beats of (127,sh15).
  - Response: out_acc = 8388607, out_ovf=1.
- Async reset:
  - Stimulus: reset=0 mid-sequence after 2 beats, and again while in HOLD.
  - Response: outputs go to 0 immediately, no clock needed; after release, a single (-128,sh0,last) beat yields out_acc = -128.
